// File: rtl/serial_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// serial_rx
//   8N1 UART receiver, LSB first. The rx line is brought into the clock domain
//   through a two-flop synchroniser and oversampled with a free-running 16x
//   baud tick (same divider scheme as the serial transmitter). The start bit
//   is qualified at mid-bit, each data bit is sampled at its centre, and the
//   stop bit is checked. Completed bytes go into a one-entry holding register
//   with a valid/ack handshake.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst        synchronous, active-high reset
//   rx         asynchronous serial input, idle high
//   data[7:0]  last received byte, meaningful while valid=1
//   valid      byte available; level held until acknowledged
//   ack        consumer accepts data; ignored while valid=0
//   frame_err  one-cycle pulse when the stop bit is sampled low
//   overrun    one-cycle pulse when a byte lands on an unacknowledged one
//   busy       high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module serial_rx #(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int BAUD          = 9600,
    parameter int CLK_MUL       = CLK_FREQ / (BAUD * 16),
    parameter int CLK_MUL_WIDTH = $clog2(CLK_MUL + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    localparam logic [CLK_MUL_WIDTH-1:0] DIV_LAST = CLK_MUL_WIDTH'(CLK_MUL);
    localparam logic [CLK_MUL_WIDTH-1:0] DIV_ONE  = CLK_MUL_WIDTH'(1);

    logic                     rx_m;
    logic                     rx_s;
    logic [CLK_MUL_WIDTH-1:0] div;
    logic                     tick16;
    logic [2:0]               state;
    logic [3:0]               tc;
    logic [2:0]               bi;
    logic [7:0]               shift;
    logic                     stop_tick;
    logic                     byte_done;
    logic                     stop_bad;

    // ---- input synchroniser: reset to the idle (high) line level ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // ---- 16x tick generator ----
    // Free-running; deliberately not realigned to the start edge, so the
    // start-edge uncertainty is bounded by one tick (1/16 bit).
    assign tick16 = (div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
        end else if (tick16) begin
            div <= '0;
        end else begin
            div <= div + DIV_ONE;
        end
    end

    // ---- receive FSM: every transition happens on a tick ----
    // START waits 8 ticks to reach the middle of the start bit; from there
    // each further 16 ticks lands on the centre of the next bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            tc    <= 4'd0;
            bi    <= 3'd0;
        end else if (tick16) begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state <= S_START;
                        tc    <= 4'd0;
                    end
                end
                S_START: begin
                    if (tc == 4'd7) begin
                        if (rx_s) begin
                            state <= S_IDLE;       // glitch, not a start bit
                        end else begin
                            state <= S_DATA;
                            tc    <= 4'd0;
                            bi    <= 3'd0;
                        end
                    end else begin
                        tc <= tc + 4'd1;
                    end
                end
                S_DATA: begin
                    if (tc == 4'd15) begin
                        tc <= 4'd0;
                        if (bi == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bi <= bi + 3'd1;
                        end
                    end else begin
                        tc <= tc + 4'd1;
                    end
                end
                S_STOP: begin
                    if (tc == 4'd15) begin
                        state <= rx_s ? S_IDLE : S_BREAK;
                    end else begin
                        tc <= tc + 4'd1;
                    end
                end
                S_BREAK: begin
                    // A line held low reports one framing error, then waits
                    // here rather than decoding a stream of 0x00 bytes.
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ---- data shift register: LSB arrives first, so shift right ----
    always_ff @(posedge clk) begin
        if (tick16 && state == S_DATA && tc == 4'd15) begin
            shift <= {rx_s, shift[7:1]};
        end
    end

    assign stop_tick = tick16 && (state == S_STOP) && (tc == 4'd15);
    assign byte_done = stop_tick && rx_s;
    assign stop_bad  = stop_tick && !rx_s;

    // ---- holding register and status pulses ----
    // A completing byte takes priority over an ack in the same cycle, so the
    // new byte is never lost; overrun only flags a byte nobody accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            data      <= 8'd0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= byte_done && valid && !ack;
            if (byte_done) begin
                data  <= shift;
                valid <= 1'b1;
            end else if (valid && ack) begin
                valid <= 1'b0;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule
